// File: rtl/am_envelope_agc_pkg.sv
// Shared types and constants for the AM envelope AGC slice.
package am_demod_pkg;

   typedef logic signed [7:0] sample_t;
   typedef logic        [7:0] dac_t;

   localparam dac_t DAC_MID = 8'd128;

   typedef enum logic [1:0] {
      S_INIT,
      S_ACQ,
      S_UPD
   } agc_state_e;

endpackage

// File: rtl/am_envelope_agc_if.sv
// Sample-in / audio-out bundle of the envelope AGC, plus the FSM state for debug.
// sample_en and dout_valid are single-cycle strobes with no back-pressure: the
// producer may strobe every cycle and the consumer must accept every dout_valid.
interface am_envelope_agc_if;
   import am_demod_pkg::*;

   logic       sample_en;
   sample_t    din;
   dac_t       dout;
   logic       dout_valid;
   logic       signal_present;
   logic [2:0] cur_shift;
   agc_state_e state;

   modport master (
      output sample_en, din,
      input  dout, dout_valid, signal_present, cur_shift, state
   );

   modport slave (
      input  sample_en, din,
      output dout, dout_valid, signal_present, cur_shift, state
   );

endinterface

// File: rtl/am_envelope_agc_shift_calc.sv
// Power-of-two gain selection: smallest shift that lifts the span to half scale.
module agc_shift_calc #(
   parameter int MAX_SHIFT = 4
) (
   input  logic [8:0] span_i,
   output logic [2:0] shift_o
);

   logic [15:0] span_w;

   assign span_w = {7'd0, span_i};

   // Descending scan so the lowest qualifying shift wins.
   always_comb begin
      shift_o = 3'(MAX_SHIFT);
      for (int k = MAX_SHIFT; k >= 0; k--) begin
         if ((span_w << k) >= 16'd128) begin
            shift_o = 3'(k);
         end
      end
   end

endmodule

// File: rtl/am_envelope_agc.sv
// Envelope DC removal and windowed power-of-two AGC, producing offset-binary DAC audio.
module am_envelope_agc
   import am_demod_pkg::*;
#(
   parameter int WIN_LEN   = 1024,
   parameter int MAX_SHIFT = 4,
   parameter int MIN_SPAN  = 4
) (
   input  logic          clk,
   input  logic          rst,
   am_envelope_agc_if.slave agc_if
);

   localparam int CW = $clog2(WIN_LEN);
   localparam int YW = 9 + MAX_SHIFT;

   agc_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   sample_t             max_q, max_d, min_q, min_d;
   sample_t             snap_max_q, snap_max_d, snap_min_q, snap_min_d;
   logic signed [8:0]   offset_q, offset_d;
   logic [2:0]          shift_q, shift_d;
   logic                present_q, present_d;

   logic                v1_q, v2_q;
   logic signed [8:0]   diff1_q;
   logic [2:0]          shift1_q;
   logic                pres1_q;
   dac_t                dout_q, dout_d;

   sample_t             din;
   logic                en;
   sample_t             nmax, nmin;
   logic signed [8:0]   sum_s, span_s, offset_new, diff_s;
   logic [8:0]          span;
   logic [2:0]          shift_new;
   logic signed [YW-1:0] y_ext, y_s;
   logic                sat_hi, sat_lo;
   logic signed [7:0]   y8;

   assign din = agc_if.din;
   assign en  = agc_if.sample_en;

   assign nmax = (din > max_q) ? din : max_q;
   assign nmin = (din < min_q) ? din : min_q;

   assign sum_s      = {snap_max_q[7], snap_max_q} + {snap_min_q[7], snap_min_q};
   assign span_s     = {snap_max_q[7], snap_max_q} - {snap_min_q[7], snap_min_q};
   assign span       = span_s;
   assign offset_new = sum_s >>> 1;

   agc_shift_calc #(.MAX_SHIFT(MAX_SHIFT)) u_shift_calc (
      .span_i  (span),
      .shift_o (shift_new)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      max_d      = max_q;
      min_d      = min_q;
      snap_max_d = snap_max_q;
      snap_min_d = snap_min_q;
      offset_d   = offset_q;
      shift_d    = shift_q;
      present_d  = present_q;
      case (state_q)
         S_INIT: begin
            if (en) begin
               max_d   = din;
               min_d   = din;
               cnt_d   = CW'(1);
               state_d = S_ACQ;
            end
         end
         S_ACQ: begin
            if (en) begin
               // A count of zero means the update cycle saw no sample: start fresh.
               if (cnt_q == '0) begin
                  max_d = din;
                  min_d = din;
                  cnt_d = CW'(1);
               end else begin
                  max_d = nmax;
                  min_d = nmin;
                  if (cnt_q == CW'(WIN_LEN - 1)) begin
                     snap_max_d = nmax;
                     snap_min_d = nmin;
                     cnt_d      = '0;
                     state_d    = S_UPD;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         end
         S_UPD: begin
            offset_d  = offset_new;
            shift_d   = shift_new;
            present_d = (span >= 9'(MIN_SPAN));
            state_d   = S_ACQ;
            if (en) begin
               max_d = din;
               min_d = din;
               cnt_d = CW'(1);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         max_q      <= '0;
         min_q      <= '0;
         snap_max_q <= '0;
         snap_min_q <= '0;
         offset_q   <= '0;
         shift_q    <= '0;
         present_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         max_q      <= max_d;
         min_q      <= min_d;
         snap_max_q <= snap_max_d;
         snap_min_q <= snap_min_d;
         offset_q   <= offset_d;
         shift_q    <= shift_d;
         present_q  <= present_d;
      end
   end

   // Stage 1 captures offset-corrected sample with the gain/mute it must use.
   assign diff_s = {din[7], din} - offset_q;

   // Stage 2: shift, saturate to signed 8 bits, convert to offset binary.
   assign y_ext  = YW'(diff1_q);
   assign y_s    = y_ext <<< shift1_q;
   assign sat_hi = ~y_s[YW-1] & (|y_s[YW-2:7]);
   assign sat_lo = y_s[YW-1] & ~(&y_s[YW-2:7]);

   always_comb begin
      y8 = y_s[7:0];
      if (sat_hi) begin
         y8 = 8'sh7f;
      end else if (sat_lo) begin
         y8 = -8'sd128;
      end
      dout_d = pres1_q ? {~y8[7], y8[6:0]} : DAC_MID;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q     <= 1'b0;
         diff1_q  <= '0;
         shift1_q <= '0;
         pres1_q  <= 1'b0;
         v2_q     <= 1'b0;
         dout_q   <= DAC_MID;
      end else begin
         v1_q <= en;
         v2_q <= v1_q;
         if (en) begin
            diff1_q  <= diff_s;
            shift1_q <= shift_q;
            pres1_q  <= present_q;
         end
         if (v1_q) begin
            dout_q <= dout_d;
         end
      end
   end

   assign agc_if.dout           = dout_q;
   assign agc_if.dout_valid     = v2_q;
   assign agc_if.signal_present = present_q;
   assign agc_if.cur_shift      = shift_q;
   assign agc_if.state          = state_q;

endmodule

// File: tb/tb_am_envelope_agc.sv
// Self-checking bench for am_envelope_agc with a behavioural window/gain model.
module tb_am_envelope_agc;
   import am_demod_pkg::*;

   localparam int WIN  = 16;
   localparam int MAXS = 4;
   localparam int MINS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   am_envelope_agc_if bif ();

   am_envelope_agc #(
      .WIN_LEN   (WIN),
      .MAX_SHIFT (MAXS),
      .MIN_SPAN  (MINS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .agc_if (bif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   // behavioural model state
   int      m_cnt, m_off, m_shift, p_off, p_shift;
   bit      m_pres, p_pres, m_in_upd;
   sample_t m_max, m_min;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_dout(sample_t d, int off, int sh, bit pres);
      int y;
      if (!pres) return 8'd128;
      y = (int'(d) - off) * (1 << sh);
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      return 8'(y + 128);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_in_upd = 0; m_off = 0; m_shift = 0; m_pres = 0;
      m_max = 0; m_min = 0;
   endtask

   task automatic win_done();
      int s, span, k;
      s = int'(m_max) + int'(m_min);
      p_off = (s >= 0) ? s / 2 : -((1 - s) / 2);
      span = int'(m_max) - int'(m_min);
      k = 0;
      while (k < MAXS && (span << k) < 128) k++;
      p_shift = k;
      p_pres = (span >= MINS);
   endtask

   // One clock cycle of stimulus; expected output pushed as the sample is driven.
   task automatic step(input bit en, input sample_t d);
      bit upd_now;
      upd_now = m_in_upd;
      bif.sample_en = en;
      bif.din = d;
      if (en) exp_q.push_back(exp_dout(d, m_off, m_shift, m_pres));
      m_in_upd = 0;
      if (en) begin
         if (upd_now || m_cnt == 0) begin
            m_max = d; m_min = d; m_cnt = 1;
         end else begin
            if (d > m_max) m_max = d;
            if (d < m_min) m_min = d;
            m_cnt++;
            if (m_cnt == WIN) begin
               win_done();
               m_cnt = 0;
               m_in_upd = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (upd_now) begin
         m_off = p_off; m_shift = p_shift; m_pres = p_pres;
      end
      bif.sample_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && bif.dout_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
         end else begin
            chk("dout", 32'(bif.dout), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      bif.sample_en = 1'b0;
      bif.din = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", 32'(bif.dout), 32'd128);
      chk("rst_valid", 32'(bif.dout_valid), 32'd0);
      chk("rst_present", 32'(bif.signal_present), 32'd0);
      chk("rst_shift", 32'(bif.cur_shift), 32'd0);
      chk("rst_state", 32'(bif.state), 32'(S_INIT));
      rst = 1'b0;

      // constant input: no signal, muted, max gain
      for (int i = 0; i < 3 * WIN; i++) step(1'b1, 8'sd40);
      repeat (3) step(1'b0, 8'sd0);
      chk("const_shift", 32'(bif.cur_shift), 32'd4);
      chk("const_present", 32'(bif.signal_present), 32'd0);

      // square wave 50/10
      for (int i = 0; i < 2 * WIN; i++) step(1'b1, (i % 2 == 0) ? 8'sd50 : 8'sd10);
      repeat (3) step(1'b0, 8'sd0);
      chk("sq_shift", 32'(bif.cur_shift), 32'd2);
      chk("sq_present", 32'(bif.signal_present), 32'd1);
      step(1'b1, 8'sd50);
      chk("lat1_valid", 32'(bif.dout_valid), 32'd0);
      step(1'b0, 8'sd0);
      chk("lat2_valid", 32'(bif.dout_valid), 32'd1);
      chk("lat2_dout", 32'(bif.dout), 32'd208);
      step(1'b0, 8'sd0);
      chk("hold_valid", 32'(bif.dout_valid), 32'd0);
      chk("hold_dout", 32'(bif.dout), 32'd208);
      step(1'b1, 8'sd10);
      step(1'b1, 8'sd127);
      step(1'b1, -8'sd128);
      step(1'b0, 8'sd0);
      chk("sat_lo_dout", 32'(bif.dout), 32'd0);

      // full-scale fill to finish the window, then a sample in the update cycle
      for (int i = 0; i < WIN && !m_in_upd; i++) step(1'b1, (i % 2 == 0) ? 8'sd127 : -8'sd128);
      chk("upd_state", 32'(bif.state), 32'(S_UPD));
      step(1'b1, 8'sd20);
      step(1'b0, 8'sd0);
      chk("upd_old_dout", 32'(bif.dout), 32'd88);
      chk("full_shift", 32'(bif.cur_shift), 32'd0);
      for (int i = 0; i < WIN - 2; i++) step(1'b1, sample_t'($urandom_range(0, 200) - 100));
      chk("win_not_done", 32'(bif.state), 32'(S_ACQ));
      step(1'b1, sample_t'($urandom_range(0, 200) - 100));
      chk("win_done", 32'(bif.state), 32'(S_UPD));
      repeat (2) step(1'b0, 8'sd0);

      // floor rounding: max=-3, min=-8 -> offset -6, span 5
      for (int i = 0; i < WIN; i++) step(1'b1, (i % 2 == 0) ? -8'sd3 : -8'sd8);
      repeat (2) step(1'b0, 8'sd0);
      chk("floor_shift", 32'(bif.cur_shift), 32'd4);
      chk("floor_present", 32'(bif.signal_present), 32'd1);
      step(1'b1, -8'sd3);
      step(1'b0, 8'sd0);
      chk("floor_dout", 32'(bif.dout), 32'd176);
      step(1'b1, -8'sd8);

      // random data with random gaps
      for (int i = 0; i < 120; i++) begin
         step(1'($urandom_range(0, 1)), sample_t'($urandom_range(0, 255)));
      end

      // reset with samples in flight
      step(1'b1, 8'sd33);
      step(1'b1, 8'sd34);
      rst = 1'b1;
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #1;
      chk("mid_rst_dout", 32'(bif.dout), 32'd128);
      chk("mid_rst_valid", 32'(bif.dout_valid), 32'd0);
      chk("mid_rst_present", 32'(bif.signal_present), 32'd0);
      chk("mid_rst_state", 32'(bif.state), 32'(S_INIT));
      rst = 1'b0;
      repeat (3) step(1'b0, 8'sd0);
      for (int i = 0; i < WIN - 1; i++) step(1'b1, sample_t'($urandom_range(0, 255)));
      chk("post_rst_acq", 32'(bif.state), 32'(S_ACQ));
      step(1'b1, 8'sd5);
      chk("post_rst_upd", 32'(bif.state), 32'(S_UPD));

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 8'sd0);
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
